// File: rtl/parking_controller.sv
// ============================================================================
// parking_controller
// ----------------------------------------------------------------------------
// Occupancy counter and entry-gate sequencer for the parking lot.
//
// The one-cycle "car entered" / "car exited" pulses from the entry/exit
// sensor FSM are the authoritative source for the number of cars inside.
// The entry barrier opens on a driver request only while a space will be
// free, and closes again once a car passes or after a timeout.
//
// Parameters
//   CAPACITY      maximum number of cars (1 .. 2**CNT_W-1)
//   CNT_W         width of the occupancy count
//   GATE_TIMEOUT  cycles the gate stays open with no car passing (>= 1)
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   entry_req  in   1      driver request to open the entry gate
//   car_in     in   1      1-cycle pulse: car fully entered
//   car_out    in   1      1-cycle pulse: car fully exited
//   gate_open  out  1      registered, 1 = entry barrier raised
//   count      out  CNT_W  registered number of cars inside
//   full       out  1      count == CAPACITY
//   empty      out  1      count == 0
//   reject     out  1      1-cycle pulse: request refused, lot full
//   timeout    out  1      1-cycle pulse: gate closed with no car passing
//   err_ovf    out  1      1-cycle pulse: car_in while already full
//   err_unf    out  1      1-cycle pulse: car_out while already empty
// ============================================================================
module parking_controller #(
    parameter int CAPACITY     = 16,
    parameter int CNT_W        = 5,
    parameter int GATE_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             car_in,
    input  logic             car_out,
    output logic             gate_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             timeout,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam int TIMER_W = $clog2(GATE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   CAP_VAL    = CNT_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GATE_TIMEOUT - 1);

    typedef enum logic {
        G_CLOSED = 1'b0,
        G_OPEN   = 1'b1
    } gate_state_t;

    gate_state_t        state;
    logic [TIMER_W-1:0] timer;

    logic [CNT_W-1:0] countNext;
    logic             ovfNext;
    logic             unfNext;

    // Work out what the occupancy count becomes at this edge. Simultaneous
    // entry and exit cancel out, and the count saturates at both ends
    // instead of wrapping; hitting an end flags the matching error so the
    // sensor problem can be reported one cycle later.
    always_comb begin
        countNext = count;
        ovfNext   = 1'b0;
        unfNext   = 1'b0;
        if (car_in && !car_out) begin
            if (count == CAP_VAL) begin
                ovfNext = 1'b1;
            end else begin
                countNext = count + CNT_W'(1);
            end
        end else if (car_out && !car_in) begin
            if (count == '0) begin
                unfNext = 1'b1;
            end else begin
                countNext = count - CNT_W'(1);
            end
        end
    end

    // Occupancy register and its error pulses. This runs independently of
    // the gate, since cars can be counted whether or not the barrier moved.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            count   <= countNext;
            err_ovf <= ovfNext;
            err_unf <= unfNext;
        end
    end

    // Gate sequencer. A request is judged against the count that is about
    // to be stored, so a car arriving in the same cycle as the request that
    // fills the last space causes a reject. While the gate is open, a
    // passing car closes it immediately and wins over an expiring timer.
    // The timer loads GATE_TIMEOUT-1 and closes on reaching zero, so an
    // unused gate stays up for exactly GATE_TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= G_CLOSED;
            timer     <= '0;
            gate_open <= 1'b0;
            reject    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            reject  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                G_CLOSED: begin
                    if (entry_req) begin
                        if (countNext < CAP_VAL) begin
                            state     <= G_OPEN;
                            timer     <= TIMER_LOAD;
                            gate_open <= 1'b1;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                G_OPEN: begin
                    if (car_in) begin
                        state     <= G_CLOSED;
                        gate_open <= 1'b0;
                    end else if (timer == '0) begin
                        state     <= G_CLOSED;
                        gate_open <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: begin
                    state     <= G_CLOSED;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

    // Status flags decoded straight from the count register.
    assign full  = (count == CAP_VAL);
    assign empty = (count == '0);

endmodule
